stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control FSM and time-base for a stopwatch built around a seconds counter.
- Contains a prescaler that generates the one-second tick, and a BCD MM:SS counter (min 0..MAX_MIN, sec 00..59).
- Sequences start/stop/lap/clear from single-cycle button pulses.
- Drives the display digits and the status flags consumed by the display/LED logic.

Parameters:
- CLK_DIV, 24000, clk cycles per tick; must be ≥2.
- MAX_MIN, 9, highest minute value; range 0..9.

Ports:
- clk  in  1  system clock
- res  in  1  reset, asynchronous, active-high
- btn_ss  in  1  start/stop pulse, one cycle wide, already debounced
- btn_lap  in  1  lap toggle pulse, one cycle wide
- btn_clr  in  1  clear pulse, one cycle wide
- sec_lo  out  4  displayed seconds ones, BCD 0..9
- sec_hi  out  4  displayed seconds tens, BCD 0..5
- min  out  4  displayed minutes, BCD 0..MAX_MIN
- running  out  1  high in RUN or LAP
- lap_hold  out  1  high in LAP (display frozen)
- s_pulse  out  1  one-cycle pulse coincident with each live-count increment
- ovf  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset res is asynchronous, active-high.
- Reset values: state IDLE; prescaler 0; live count 0:00; lap latch 0:00. All outputs 0 (sec_lo=sec_hi=min=0, running=lap_hold=s_pulse=ovf=0).
- All outputs are registered.
- States: IDLE, RUN, PAUSE, LAP, DONE.
- Prescaler `pre`:
  - In RUN/LAP, counts 0..CLK_DIV-1 and wraps to 0.
  - In PAUSE, holds its value, so a partial second is preserved.
  - In IDLE, is forced to 0.
  - In DONE, holds.
- Tick: tick = (state is RUN or LAP) and pre==CLK_DIV-1, evaluated on current-state values.
- On the tick edge:
  - Live count increments: sec_lo wraps 9→0 carrying to sec_hi; sec_hi wraps 5→0 carrying to min.
  - s_pulse=1 for that one cycle; 0 otherwise.
- Saturation: a tick while live count is MAX_MIN:59 does not wrap. The count holds at MAX_MIN:59, state→DONE, ovf=1. s_pulse is not asserted for that tick.
- Transitions (btn_* sampled at the clock edge; priority clr > ss > lap):
  - IDLE: btn_ss → RUN. btn_clr → IDLE (no-op). btn_lap ignored.
  - RUN: btn_ss → PAUSE. btn_lap → LAP, latching the live count (pre-increment value if a tick hits the same edge). btn_clr ignored.
  - LAP: btn_lap → RUN, display returns to live. btn_ss → PAUSE, display returns to live. btn_clr ignored. The live count keeps running.
  - PAUSE: btn_ss → RUN. btn_clr → IDLE (live count, lap latch, prescaler cleared). btn_lap ignored.
  - DONE: only btn_clr → IDLE. Everything else is ignored.
- A tick on the same edge as btn_ss in RUN/LAP still increments. The prescaler then wraps to 0 and holds in PAUSE.
- Display mux: in LAP, display = lap latch. Otherwise display = live count. The registered outputs update the cycle after any state or count change.
- Saturation while in LAP → DONE; display switches to live (MAX_MIN:59).
- Reset asserted mid-operation returns to the reset values immediately (asynchronous). The first state change after release needs a new btn_ss.

Test Plan:
- CLK_DIV=4, MAX_MIN=9. Reset, release, btn_ss pulse → running=1. First s_pulse at pre==3 then every 4 clks. After 12 ticks, display 0:12.
- Run to 0:05 plus 2 prescaler counts, btn_ss → PAUSE, wait 20 clks → display stays 0:05. btn_ss again → next tick arrives after exactly 2 clks (prescaler preserved).
- RUN at 0:59, tick → display 1:00 with s_pulse=1. btn_lap at 1:03 → lap_hold=1 and display frozen at 1:03 while the live count advances. After 5 more ticks, btn_lap → display 1:08.
- Set btn_ss and btn_lap in the same cycle in RUN → PAUSE, lap_hold=0. btn_clr in RUN → ignored. btn_clr in PAUSE → 0:00, IDLE, pre=0.
- Run to 9:59, next tick → ovf=1, running=0, display 9:59, no s_pulse. btn_ss ignored. btn_clr → 0:00, ovf=0.
- Assert res for 3 ns mid-RUN at 2:34 (between edges) → all outputs 0 immediately. After release, the count stays 0:00 until btn_ss.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: prescaled one-second tick, saturating BCD MM:SS counter,
// start/stop/lap/clear sequencing and registered display/status outputs.
module stopwatch_ctrl #(
  parameter int CLK_DIV = 24000,
  parameter int MAX_MIN = 9
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min,
  output logic       running,
  output logic       lap_hold,
  output logic       s_pulse,
  output logic       ovf
);
  localparam int                PRE_W     = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [11:0]       COUNT_MAX = {4'(MAX_MIN), 4'd5, 4'd9};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_LAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [11:0]      live_q, live_d;  // {min, sec_hi, sec_lo}, BCD
  logic [11:0]      lap_q, lap_d;
  logic [11:0]      disp_q, disp_d;
  logic             running_q, running_d;
  logic             lap_hold_q, lap_hold_d;
  logic             s_pulse_q, s_pulse_d;
  logic             ovf_q, ovf_d;

  logic        counting, tick, sat, clear;
  logic [11:0] live_inc;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (pre_q == PRE_LAST);
  assign sat      = tick && (live_q == COUNT_MAX);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    live_inc = live_q;
    if (live_q[3:0] != 4'd9) begin
      live_inc[3:0] = live_q[3:0] + 4'd1;
    end else begin
      live_inc[3:0] = 4'd0;
      if (live_q[7:4] != 4'd5) begin
        live_inc[7:4] = live_q[7:4] + 4'd1;
      end else begin
        live_inc[7:4]  = 4'd0;
        live_inc[11:8] = live_q[11:8] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE:  if (btn_clr) clear = 1'b1; else if (btn_ss) state_d = S_RUN;
      S_RUN: begin
        if (btn_ss) begin
          state_d = S_PAUSE;
        end else if (btn_lap) begin
          state_d = S_LAP;
          lap_d   = live_q;
        end
      end
      S_LAP:   if (btn_ss) state_d = S_PAUSE; else if (btn_lap) state_d = S_RUN;
      S_PAUSE: if (btn_clr) clear = 1'b1; else if (btn_ss) state_d = S_RUN;
      S_DONE:  if (btn_clr) clear = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Saturation only happens while counting, so it never collides with an accepted clear.
    if (sat)   state_d = S_DONE;
    if (clear) begin
      state_d = S_IDLE;
      lap_d   = '0;
    end
  end

  always_comb begin
    pre_d  = pre_q;
    live_d = live_q;
    if (counting)               pre_d = tick ? '0 : pre_q + 1'b1;
    else if (state_q == S_IDLE) pre_d = '0;
    if (tick && !sat) live_d = live_inc;
    if (clear) begin
      pre_d  = '0;
      live_d = '0;
    end
  end

  always_comb begin
    disp_d     = (state_q == S_LAP) ? lap_q : live_q;
    running_d  = counting;
    lap_hold_d = (state_q == S_LAP);
    s_pulse_d  = tick && !sat;
    ovf_d      = (state_q == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      s_pulse_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
      s_pulse_q  <= s_pulse_d;
      ovf_q      <= ovf_d;
    end
  end

  assign min      = disp_q[11:8];
  assign sec_hi   = disp_q[7:4];
  assign sec_lo   = disp_q[3:0];
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign s_pulse  = s_pulse_q;
  assign ovf      = ovf_q;

endmodule
